// File: rtl/fp_sqrt_seq_pkg.sv
// Shared definitions for the FP square-root microsequencer:
// state encoding, default control words and step indices.
package fp_sqrt_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_INIT = 3'd2,
    ST_ITER = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  localparam int          CTRL_W_DEF   = 14;

  localparam logic [13:0] CW_LOAD_DEF  = 14'b11001000000000;
  localparam logic [13:0] CW_INIT_DEF  = 14'b01010001000000;
  localparam logic [13:0] CW_STEP0_DEF = 14'b01011001010100;
  localparam logic [13:0] CW_STEP1_DEF = 14'b01011011010000;
  localparam logic [13:0] CW_STEP2_DEF = 14'b01011011101100;
  localparam logic [13:0] CW_STEP3_DEF = 14'b01010011000000;
  localparam logic [13:0] CW_OUT_DEF   = 14'b00111011000001;

  // Register write enables; cleared while the datapath is stalled.
  localparam logic [13:0] WE_MASK_DEF  = 14'b11000000000001;

  localparam logic [1:0]  STEP_0 = 2'd0;
  localparam logic [1:0]  STEP_1 = 2'd1;
  localparam logic [1:0]  STEP_2 = 2'd2;
  localparam logic [1:0]  STEP_3 = 2'd3;

endpackage

// File: rtl/fp_sqrt_seq_decode.sv
// Control-word decoder: maps registered state/step to the datapath
// control word and blanks the write enables while stalled.
module fp_sqrt_seq_decode
  import fp_sqrt_seq_pkg::*;
#(
  parameter int                CTRL_W   = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] CW_LOAD  = CW_LOAD_DEF,
  parameter logic [CTRL_W-1:0] CW_INIT  = CW_INIT_DEF,
  parameter logic [CTRL_W-1:0] CW_STEP0 = CW_STEP0_DEF,
  parameter logic [CTRL_W-1:0] CW_STEP1 = CW_STEP1_DEF,
  parameter logic [CTRL_W-1:0] CW_STEP2 = CW_STEP2_DEF,
  parameter logic [CTRL_W-1:0] CW_STEP3 = CW_STEP3_DEF,
  parameter logic [CTRL_W-1:0] CW_OUT   = CW_OUT_DEF,
  parameter logic [CTRL_W-1:0] WE_MASK  = WE_MASK_DEF
) (
  input  state_t            state,
  input  logic [1:0]        step,
  input  logic              stall,
  output logic [CTRL_W-1:0] ctrl
);

  logic [CTRL_W-1:0] word_next;

  // Select the raw control word for the current state and step.
  always_comb begin
    word_next = '0;
    unique case (state)
      ST_IDLE: word_next = '0;
      ST_LOAD: word_next = CW_LOAD;
      ST_INIT: word_next = CW_INIT;
      ST_ITER: begin
        unique case (step)
          STEP_0:  word_next = CW_STEP0;
          STEP_1:  word_next = CW_STEP1;
          STEP_2:  word_next = CW_STEP2;
          default: word_next = CW_STEP3;
        endcase
      end
      ST_OUT:  word_next = CW_OUT;
      default: word_next = '0;
    endcase
  end

  // Per-bit gating: write-enable bits drop while stalled, others pass.
  // IDLE already decodes to zero, so gating there is harmless.
  generate
    for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_mask
      if (WE_MASK[gi]) begin : g_we
        assign ctrl[gi] = word_next[gi] & ~stall;
      end else begin : g_pass
        assign ctrl[gi] = word_next[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/fp_sqrt_sequencer.sv
// Microsequencer for the iterative FP square-root datapath:
// start/done handshake, runtime iteration count, stall and abort.
module fp_sqrt_sequencer
  import fp_sqrt_seq_pkg::*;
#(
  parameter int                CTRL_W   = CTRL_W_DEF,
  parameter int                ITER_MAX = 12,
  parameter int                ITER_W   = 4,
  parameter logic [CTRL_W-1:0] CW_LOAD  = CW_LOAD_DEF,
  parameter logic [CTRL_W-1:0] CW_INIT  = CW_INIT_DEF,
  parameter logic [CTRL_W-1:0] CW_STEP0 = CW_STEP0_DEF,
  parameter logic [CTRL_W-1:0] CW_STEP1 = CW_STEP1_DEF,
  parameter logic [CTRL_W-1:0] CW_STEP2 = CW_STEP2_DEF,
  parameter logic [CTRL_W-1:0] CW_STEP3 = CW_STEP3_DEF,
  parameter logic [CTRL_W-1:0] CW_OUT   = CW_OUT_DEF,
  parameter logic [CTRL_W-1:0] WE_MASK  = WE_MASK_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ITER_W-1:0] iter_num_i,
  input  logic              stall_i,
  input  logic              abort_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ITER_W-1:0] iter_o,
  output logic [1:0]        step_o
);

  state_t            state_reg, state_next;
  logic [ITER_W-1:0] iter_reg,  iter_next;
  logic [1:0]        step_reg,  step_next;
  logic [ITER_W-1:0] count_reg, count_next;
  logic [ITER_W-1:0] count_clamped;
  logic [ITER_W-1:0] iter_last;

  // Requested count mapped into 1..ITER_MAX.
  always_comb begin
    if (iter_num_i == '0)
      count_clamped = ITER_W'(1);
    else if (iter_num_i > ITER_W'(ITER_MAX))
      count_clamped = ITER_W'(ITER_MAX);
    else
      count_clamped = iter_num_i;
  end

  assign iter_last = count_reg - ITER_W'(1);

  // State, counters and latched iteration count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      iter_reg  <= '0;
      step_reg  <= '0;
      count_reg <= ITER_W'(1);
    end else begin
      state_reg <= state_next;
      iter_reg  <= iter_next;
      step_reg  <= step_next;
      count_reg <= count_next;
    end
  end

  // Next state: abort beats stall beats normal advance; IDLE only looks at start.
  always_comb begin
    state_next = state_reg;
    iter_next  = iter_reg;
    step_next  = step_reg;
    count_next = count_reg;
    if (state_reg == ST_IDLE) begin
      if (start_i) begin
        state_next = ST_LOAD;
        count_next = count_clamped;
      end
    end else if (abort_i) begin
      state_next = ST_IDLE;
      iter_next  = '0;
      step_next  = '0;
    end else if (!stall_i) begin
      unique case (state_reg)
        ST_LOAD: state_next = ST_INIT;
        ST_INIT: begin
          state_next = ST_ITER;
          iter_next  = '0;
          step_next  = STEP_0;
        end
        ST_ITER: begin
          // The last iteration ends after step 2; its writeback step is skipped.
          if (step_reg == STEP_2 && iter_reg == iter_last) begin
            state_next = ST_OUT;
          end else if (step_reg == STEP_3) begin
            step_next = STEP_0;
            iter_next = iter_reg + ITER_W'(1);
          end else begin
            step_next = step_reg + 2'd1;
          end
        end
        ST_OUT: begin
          state_next = ST_IDLE;
          iter_next  = '0;
          step_next  = '0;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Handshake outputs; done is withheld while OUT is stalled or aborted.
  always_comb begin
    busy_o = (state_reg != ST_IDLE);
    done_o = (state_reg == ST_OUT) && !stall_i && !abort_i;
    iter_o = iter_reg;
    step_o = step_reg;
  end

  fp_sqrt_seq_decode #(
    .CTRL_W   (CTRL_W),
    .CW_LOAD  (CW_LOAD),
    .CW_INIT  (CW_INIT),
    .CW_STEP0 (CW_STEP0),
    .CW_STEP1 (CW_STEP1),
    .CW_STEP2 (CW_STEP2),
    .CW_STEP3 (CW_STEP3),
    .CW_OUT   (CW_OUT),
    .WE_MASK  (WE_MASK)
  ) u_decode (
    .state (state_reg),
    .step  (step_reg),
    .stall (stall_i),
    .ctrl  (ctrl_o)
  );

endmodule

// File: tb/tb_fp_sqrt_sequencer.sv
// Bench for fp_sqrt_sequencer: each operation is modelled as the list of
// cycles it should occupy (LOAD, INIT, iteration steps, OUT); the DUT is
// compared against that list cycle by cycle under stalls, aborts and resets.
module tb_fp_sqrt_sequencer;

  localparam logic [13:0] W_LOAD  = 14'b11001000000000;
  localparam logic [13:0] W_INIT  = 14'b01010001000000;
  localparam logic [13:0] W_OUT   = 14'b00111011000001;
  localparam logic [13:0] W_MASK  = 14'b11000000000001;

  typedef struct {
    logic [13:0] cw;
    int          it;
    int          st;
    bit          is_iter;
    bit          is_out;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  iter_num_i = '0;
  logic        stall_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [13:0] ctrl_o;
  logic        busy_o;
  logic        done_o;
  logic [3:0]  iter_o;
  logic [1:0]  step_o;

  logic [13:0] step_words [4];
  slot_t       q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  fp_sqrt_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .iter_num_i (iter_num_i),
    .stall_i    (stall_i),
    .abort_i    (abort_i),
    .ctrl_o     (ctrl_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .iter_o     (iter_o),
    .step_o     (step_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int clamp_n(input int req);
    if (req == 0) return 1;
    if (req > 12) return 12;
    return req;
  endfunction

  // Cycle list of an undisturbed operation with n iterations.
  function automatic void build_model(input int n);
    slot_t s;
    q.delete();
    s = '{cw: W_LOAD, it: 0, st: 0, is_iter: 0, is_out: 0}; q.push_back(s);
    s = '{cw: W_INIT, it: 0, st: 0, is_iter: 0, is_out: 0}; q.push_back(s);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (i == n - 1 && k == 3) break;
        s = '{cw: step_words[k], it: i, st: k, is_iter: 1, is_out: 0};
        q.push_back(s);
      end
    end
    s = '{cw: W_OUT, it: 0, st: 0, is_iter: 0, is_out: 1}; q.push_back(s);
  endfunction

  // Called at 1 time unit after a rising edge with the DUT in IDLE.
  // Slot arguments index the model list; -1 disables that disturbance.
  task automatic run_op(input int req, input int stall_slot, input int stall_len,
                        input int abort_slot, input int reset_slot, input bit pulse_start);
    int    n, total, pos, stall_left, stalls, cyc;
    bit    done_seen, stall_used, stalled, aborting, aborted;
    slot_t s;
    n = clamp_n(req);
    build_model(n);
    total = q.size();
    pos = 0; stall_left = 0; stalls = 0; cyc = 0;
    done_seen = 0; stall_used = 0; aborted = 0;

    // IDLE cycle: stall/abort alongside start must not matter here.
    start_i    = 1'b1;
    iter_num_i = req[3:0];
    stall_i    = 1'($urandom_range(0, 1));
    abort_i    = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("idle_busy", {31'd0, busy_o}, 32'd0);
    check("idle_ctrl", {18'd0, ctrl_o}, 32'd0);
    check("idle_done", {31'd0, done_o}, 32'd0);
    @(posedge clk); #1;

    while (q.size() > 0) begin
      s = q[0];
      start_i    = pulse_start ? 1'($urandom_range(0, 1)) : 1'b0;
      iter_num_i = 4'($urandom);
      if (pos == stall_slot && stall_len > 0 && !stall_used) begin
        stall_left = stall_len;
        stall_used = 1;
      end
      stalled = (stall_left > 0);
      if (stalled) stall_left--;
      aborting = (pos == abort_slot);
      stall_i  = stalled || aborting;
      abort_i  = aborting;

      if (pos == reset_slot) begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_ctrl", {18'd0, ctrl_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_iter", {28'd0, iter_o}, 32'd0);
        check("rst_step", {30'd0, step_o}, 32'd0);
        #1 rst_n = 1'b1;
        start_i = 1'b0; stall_i = 1'b0; abort_i = 1'b0;
        $display("run req=%0d n=%0d reset at slot %0d", req, n, pos);
        @(posedge clk); #1;
        return;
      end

      @(negedge clk);
      cyc++;
      if (stall_i) stalls++;
      check("ctrl", {18'd0, ctrl_o}, {18'd0, stall_i ? (s.cw & ~W_MASK) : s.cw});
      check("busy", {31'd0, busy_o}, 32'd1);
      check("done", {31'd0, done_o}, {31'd0, s.is_out && !stall_i && !abort_i});
      if (s.is_iter) begin
        check("iter", {28'd0, iter_o}, s.it);
        check("step", {30'd0, step_o}, s.st);
      end
      if (s.is_out && done_o) begin
        done_seen = 1;
        check("latency", cyc, total + stalls);
      end
      @(posedge clk); #1;
      if (aborting) begin
        aborted = 1;
        break;
      end
      if (!stalled) begin
        void'(q.pop_front());
        pos++;
      end
    end

    start_i = 1'b0; stall_i = 1'b0; abort_i = 1'b0;
    if (aborted) begin
      @(negedge clk);
      check("abort_busy", {31'd0, busy_o}, 32'd0);
      check("abort_ctrl", {18'd0, ctrl_o}, 32'd0);
      check("abort_done", {31'd0, done_o}, 32'd0);
      check("abort_iter", {28'd0, iter_o}, 32'd0);
      @(posedge clk); #1;
      $display("run req=%0d n=%0d aborted at slot %0d", req, n, pos);
    end else begin
      check("done_seen", {31'd0, done_seen}, 32'd1);
      $display("run req=%0d n=%0d cycles=%0d stalls=%0d", req, n, cyc, stalls);
    end
  endtask

  initial begin
    int req, n, total, st_slot, st_len, ab_slot;
    bit pulse;
    step_words[0] = 14'b01011001010100;
    step_words[1] = 14'b01011011010000;
    step_words[2] = 14'b01011011101100;
    step_words[3] = 14'b01010011000000;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("reset_ctrl", {18'd0, ctrl_o}, 32'd0);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_done", {31'd0, done_o}, 32'd0);
    check("reset_iter", {28'd0, iter_o}, 32'd0);
    check("reset_step", {30'd0, step_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed operations
    run_op(12, -1, 0, -1, -1, 0);          // full length, 50 cycles
    run_op(0,  -1, 0, -1, -1, 0);          // N=1, 6 cycles
    run_op(15, -1, 0, -1, -1, 0);          // clamped to 12
    run_op(3, 2 + 4 * 1 + 2, 5, -1, -1, 0); // stall at iter 1 step 2, 19 cycles
    run_op(6, -1, 0, 2 + 4 * 4, -1, 0);    // abort at iter 4 with stall
    run_op(5, -1, 0, -1, -1, 0);           // normal run after abort
    run_op(7, -1, 0, -1, -1, 1);           // start pulses and new counts while busy
    run_op(2, 9, 3, -1, -1, 0);            // stall held in OUT
    run_op(5, -1, 0, -1, 2 + 4 * 2 + 1, 0); // async reset mid-iteration
    run_op(4, -1, 0, -1, -1, 0);           // normal run after reset

    // Randomized operations
    for (int r = 0; r < 25; r++) begin
      req     = int'($urandom_range(0, 15));
      n       = clamp_n(req);
      total   = 4 * n + 2;
      st_slot = int'($urandom_range(0, total - 1));
      st_len  = int'($urandom_range(0, 4));
      ab_slot = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, total - 1)) : -1;
      pulse   = 1'($urandom_range(0, 1));
      run_op(req, st_slot, st_len, ab_slot, -1, pulse);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
